// File: rtl/tdl_pkg.sv
// Shared types and sizing helpers for the tapped-delay-line sequencer.
package tdl_pkg;

    localparam int TDL_SPAN_DEFAULT = 16;
    localparam int TDL_OSR_DEFAULT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } tdl_state_t;

    // Bits needed to hold any value in 0..max_value (at least one bit).
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/tdl_sequencer_if.sv
// Bit-source handshake plus delay-line control and status, bundled as one port.
interface tdl_sequencer_if;
    import tdl_pkg::*;

    // in_bit/in_last are taken on a rising edge where in_valid && in_ready;
    // in_ready never looks at in_valid, so the source may hold in_valid high.
    logic       in_bit;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       tdl_in;
    logic       tdl_shift;
    logic       out_valid;
    logic       busy;
    logic       flush_done;
    logic       underrun;
    tdl_state_t state;

    modport master (
        output in_bit, in_valid, in_last,
        input  in_ready, tdl_in, tdl_shift, out_valid, busy, flush_done, underrun, state
    );

    modport slave (
        input  in_bit, in_valid, in_last,
        output in_ready, tdl_in, tdl_shift, out_valid, busy, flush_done, underrun, state
    );

endinterface

// File: rtl/tdl_slot_timer.sv
// Phase counter 0..OSR-1; slot marks the last phase of each symbol period.
module tdl_slot_timer
    import tdl_pkg::*;
#(
    parameter int OSR = TDL_OSR_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic slot
);

    localparam int            PW   = cnt_width(OSR - 1);
    localparam logic [PW-1:0] LAST = PW'(OSR - 1);

    logic [PW-1:0] phase;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            phase <= '0;
        end else if (phase == LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign slot = (phase == LAST);

endmodule

// File: rtl/tdl_sequencer.sv
// Feeds a tapped delay line one symbol per slot, tracks fill level and
// flushes the line with SPAN zeros after the last bit of a burst.
module tdl_sequencer
    import tdl_pkg::*;
#(
    parameter int SPAN = TDL_SPAN_DEFAULT,
    parameter int OSR  = TDL_OSR_DEFAULT
) (
    input logic             clock,
    input logic             reset,
    tdl_sequencer_if.slave  bus
);

    localparam int            FW        = cnt_width(SPAN + 1);
    localparam int            LW        = cnt_width(SPAN);
    localparam logic [FW-1:0] FILL_FULL = FW'(SPAN + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(SPAN);
    localparam logic [LW-1:0] FLUSH_LEN = LW'(SPAN);

    tdl_state_t    state, state_next;
    logic [FW-1:0] fill_cnt;
    logic [LW-1:0] flush_cnt;
    logic          slot;
    logic          ready;
    logic          shift;
    logic          shift_bit;
    logic          flush_inc;
    logic          set_flush_done;
    logic          set_underrun;
    logic          go_idle;
    logic          fill_nearly_full;
    logic          tdl_in_q;
    logic          tdl_shift_q;
    logic          out_valid_q;
    logic          flush_done_q;
    logic          underrun_q;

    tdl_slot_timer #(.OSR(OSR)) u_slot_timer (
        .clock (clock),
        .reset (reset),
        .clear (state == ST_IDLE),
        .slot  (slot)
    );

    // A shift taken in FILL at this level makes the line full.
    assign fill_nearly_full = (fill_cnt >= FILL_LAST);

    always_comb begin
        state_next     = state;
        ready          = 1'b0;
        shift          = 1'b0;
        shift_bit      = 1'b0;
        flush_inc      = 1'b0;
        set_flush_done = 1'b0;
        set_underrun   = 1'b0;
        go_idle        = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    shift      = 1'b1;
                    shift_bit  = bus.in_bit;
                    state_next = bus.in_last ? ST_FLUSH : ST_FILL;
                end
            end
            ST_FILL, ST_RUN: begin
                ready = slot;
                if (slot) begin
                    shift = 1'b1;
                    if (bus.in_valid) begin
                        shift_bit = bus.in_bit;
                        if (bus.in_last) begin
                            state_next = ST_FLUSH;
                        end
                    end else begin
                        set_underrun = 1'b1;
                    end
                    if (state == ST_FILL && state_next == ST_FILL && fill_nearly_full) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                // Zero shifts stop at SPAN; the done pulse gets its own cycle before IDLE.
                if (flush_done_q) begin
                    go_idle    = 1'b1;
                    state_next = ST_IDLE;
                end else if (flush_cnt == FLUSH_LEN) begin
                    set_flush_done = 1'b1;
                end else if (slot) begin
                    shift     = 1'b1;
                    flush_inc = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fill_cnt     <= '0;
            flush_cnt    <= '0;
            tdl_in_q     <= 1'b0;
            tdl_shift_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            tdl_shift_q  <= shift;
            tdl_in_q     <= shift_bit;
            flush_done_q <= set_flush_done;
            if (set_underrun) begin
                underrun_q <= 1'b1;
            end
            if (go_idle) begin
                fill_cnt    <= '0;
                flush_cnt   <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (shift && fill_cnt != FILL_FULL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
                if (flush_inc) begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
                out_valid_q <= (fill_cnt == FILL_FULL);
            end
        end
    end

    assign bus.in_ready   = ready & reset;
    assign bus.tdl_in     = tdl_in_q;
    assign bus.tdl_shift  = tdl_shift_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.flush_done = flush_done_q;
    assign bus.underrun   = underrun_q;
    assign bus.state      = state;

endmodule

// File: tb/tb_tdl_sequencer.sv
// Directed bench for tdl_sequencer: scoreboard of shifted bits plus timing checks.
module tb_tdl_sequencer;
    import tdl_pkg::*;

    localparam int SPAN = 16;
    localparam int OSR  = 4;

    logic clock;
    logic reset;

    tdl_sequencer_if bus ();
    tdl_sequencer_if bus1 ();

    tdl_sequencer #(.SPAN(SPAN), .OSR(OSR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    tdl_sequencer #(.SPAN(SPAN), .OSR(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard
    logic [0:0] exp_q[$];
    int   pulses           = 0;
    int   last_burst_pulses = 0;
    logic flush_armed      = 1'b0;
    logic fd_due           = 1'b0;
    logic idle_due         = 1'b0;
    logic chk_ov_next      = 1'b0;
    int   last_acc         = 0;
    int   first_acc_cyc    = 0;

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (idle_due) begin
                chk("busy_after_flush", bus.busy, 0);
                idle_due = 1'b0;
            end
            if (fd_due) begin
                chk("flush_done_pulse", bus.flush_done, 1);
                fd_due            = 1'b0;
                idle_due          = 1'b1;
                last_burst_pulses = pulses;
                pulses            = 0;
                flush_armed       = 1'b0;
            end else begin
                chk("flush_done_quiet", bus.flush_done, 0);
            end
            if (chk_ov_next) begin
                chk("out_valid_rise", bus.out_valid, 1);
                chk_ov_next = 1'b0;
            end
            if (bus.tdl_shift === 1'b1) begin
                chk("queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("tdl_in", bus.tdl_in, exp_q.pop_front());
                end
                pulses++;
                if (pulses == SPAN + 1) begin
                    chk("out_valid_low_at_full_shift", bus.out_valid, 0);
                    chk_ov_next = 1'b1;
                end
                if (flush_armed && exp_q.size() == 0) fd_due = 1'b1;
            end
        end
    end

    // driver tasks
    task automatic take_slot(input logic valid, input logic b, input logic last, input logic first);
        bit done = 0;
        bus.in_valid = valid;
        bus.in_bit   = b;
        bus.in_last  = last;
        for (int t = 0; t < 4 * OSR + 4 && !done; t++) begin
            if (bus.in_ready === 1'b1) done = 1;
            @(posedge clock);
            #1;
        end
        chk("slot_reached", done, 1);
        if (done) begin
            exp_q.push_back(valid ? b : 1'b0);
            if (first) first_acc_cyc = cyc;
            else chk("slot_spacing", cyc - last_acc, OSR);
            last_acc = cyc;
            if (valid && last) begin
                repeat (SPAN) exp_q.push_back(1'b0);
                flush_armed = 1'b1;
            end
        end
    endtask

    task automatic send_burst(input int n, input bit alt, input bit with_last, input bit cont);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = alt ? logic'(i % 2 == 0) : 1'($urandom_range(0, 1));
            take_slot(1'b1, b, with_last && (i == n - 1), (i == 0) && !cont);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_flush(output int fd_cyc);
        bit seen = 0;
        fd_cyc = 0;
        for (int i = 0; i < (SPAN + 3) * OSR + 8 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (bus.flush_done === 1'b1) begin
                seen   = 1;
                fd_cyc = cyc;
            end
        end
        chk("flush_done_seen", seen, 1);
    endtask

    // directed sequence
    int   fd_cyc;
    logic b1;

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_bit   = 1'b0;
        bus1.in_last  = 1'b0;

        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_tdl_in", bus.tdl_in, 0);
        chk("rst_tdl_shift", bus.tdl_shift, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        chk("rst_underrun", bus.underrun, 0);
        chk("rst_state", bus.state, ST_IDLE);
        reset = 1'b1;
        #1;
        chk("idle_in_ready", bus.in_ready, 1);

        // streaming: 40 alternating bits
        send_burst(40, 1'b1, 1'b1, 1'b0);
        wait_flush(fd_cyc);
        @(posedge clock);
        #1;
        chk("stream_pulses", last_burst_pulses, 40 + SPAN);
        chk("stream_no_underrun", bus.underrun, 0);
        chk("stream_idle", bus.busy, 0);

        // single-bit burst, then a 5-bit burst accepted in the first IDLE cycle
        send_burst(1, 1'b0, 1'b1, 1'b0);
        wait_flush(fd_cyc);
        send_burst(5, 1'b0, 1'b1, 1'b0);
        chk("reaccept_first_idle", first_acc_cyc, fd_cyc + 2);
        chk("single_pulses", last_burst_pulses, 1 + SPAN);
        wait_flush(fd_cyc);
        @(posedge clock);
        #1;
        chk("short_pulses", last_burst_pulses, 5 + SPAN);

        // underrun: 20 bits, 3 empty slots, 10 more bits
        send_burst(20, 1'b0, 1'b0, 1'b0);
        chk("pre_underrun", bus.underrun, 0);
        repeat (3) take_slot(1'b0, 1'b0, 1'b0, 1'b0);
        chk("underrun_set", bus.underrun, 1);
        chk("underrun_state_run", bus.state, ST_RUN);
        send_burst(10, 1'b0, 1'b1, 1'b1);
        wait_flush(fd_cyc);
        @(posedge clock);
        #1;
        chk("underrun_sticky", bus.underrun, 1);
        chk("underrun_pulses", last_burst_pulses, 20 + 3 + 10 + SPAN);

        // OSR=1: back-to-back accepts
        for (int i = 0; i < 20; i++) begin
            b1            = 1'($urandom_range(0, 1));
            bus1.in_valid = 1'b1;
            bus1.in_bit   = b1;
            bus1.in_last  = (i == 19);
            chk("osr1_ready", bus1.in_ready, 1);
            @(posedge clock);
            #1;
            chk("osr1_shift", bus1.tdl_shift, 1);
            chk("osr1_bit", bus1.tdl_in, b1);
            if (i == 16) chk("osr1_ov_low", bus1.out_valid, 0);
            if (i == 17) chk("osr1_ov_high", bus1.out_valid, 1);
        end
        bus1.in_valid = 1'b0;
        bus1.in_last  = 1'b0;
        for (int j = 0; j < SPAN; j++) begin
            @(posedge clock);
            #1;
            chk("osr1_zero_shift", bus1.tdl_shift, 1);
            chk("osr1_zero_bit", bus1.tdl_in, 0);
        end
        @(posedge clock);
        #1;
        chk("osr1_flush_done", bus1.flush_done, 1);
        @(posedge clock);
        #1;
        chk("osr1_idle", bus1.busy, 0);

        // reset mid-burst while in RUN
        send_burst(25, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_state_run", bus.state, ST_RUN);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_tdl_in", bus.tdl_in, 0);
        chk("mid_rst_tdl_shift", bus.tdl_shift, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_flush_done", bus.flush_done, 0);
        chk("mid_rst_underrun", bus.underrun, 0);
        chk("mid_rst_state", bus.state, ST_IDLE);
        exp_q.delete();
        pulses      = 0;
        flush_armed = 1'b0;
        fd_due      = 1'b0;
        idle_due    = 1'b0;
        chk_ov_next = 1'b0;
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("post_rst_idle", bus.busy, 0);

        // clean burst after reset
        send_burst(20, 1'b0, 1'b1, 1'b0);
        wait_flush(fd_cyc);
        @(posedge clock);
        #1;
        chk("post_rst_pulses", last_burst_pulses, 20 + SPAN);
        chk("post_rst_underrun", bus.underrun, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tdl_sequencer.md
# tdl_sequencer

Controls a transmitter's tapped delay line. It accepts serial bits from the bit source over a valid/ready handshake and issues one shift per symbol slot, one slot every OSR clocks. It tracks how full the line is and flushes it with zeros after the last bit. It sits between the framer/bit source and the delay line plus pulse-shaping filter, and its `out_valid` tells the filter when the tap vector holds a complete window.

## Interface
- SPAN, 16: delay-line span; the line has SPAN+1 taps (out[SPAN:0]).
- OSR, 4: clocks per symbol slot (oversampling ratio), ≥1.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_bit  in  1  data bit from source.
- in_valid  in  1  in_bit valid.
- in_last  in  1  qualifies the final bit of a burst.
- in_ready  out  1  sequencer accepts in_bit this cycle.
- tdl_in  out  1  bit presented to the delay line (registered).
- tdl_shift  out  1  shift enable for the delay line, one-cycle pulse (registered).
- out_valid  out  1  delay line holds SPAN+1 valid symbols.
- busy  out  1  state ≠ IDLE.
- flush_done  out  1  one-cycle pulse at end of flush.
- underrun  out  1  sticky: a RUN/FILL slot found no valid input.

## Operation
- States: IDLE, FILL, RUN, FLUSH. Phase counter 0..OSR-1 runs in all non-IDLE states. A slot is phase == OSR-1. The phase counter resets to 0 on entry from IDLE.
- IDLE: in_ready=1.
  - Accept (in_valid && in_ready) → shift in_bit, fill_cnt=1.
  - Go to FLUSH if in_last, else FILL.
- FILL/RUN: in_ready=1 only in slot cycles.
  - Slot with in_valid: shift in_bit. Go to FLUSH if in_last.
  - Slot without in_valid: shift 0 and set underrun. State unchanged.
  - in_valid outside a slot is ignored and not accepted.
- fill_cnt counts shifts and saturates at SPAN+1. FILL→RUN when fill_cnt reaches SPAN+1.
- out_valid = (fill_cnt == SPAN+1). This holds in every state, so a burst shorter than SPAN+1 bits becomes valid partway through the flush.
- FLUSH: in_ready=0.
  - Shift 0 each slot, SPAN shifts in total, counted from the shift that carried the last bit.
  - After the final zero shift, flush_done pulses one cycle. out_valid stays at its value for that cycle.
  - Then go to IDLE: fill_cnt=0, out_valid=0.
- underrun clears only on reset.
- Every shift produces exactly one tdl_shift pulse, with tdl_in carrying the shifted bit. The delay line is not reset by this block; out_valid is the only qualifier of its contents.

## Timing
- Reset values: in_ready=0 during the reset cycle, 1 afterwards (IDLE). tdl_in=0, tdl_shift=0, out_valid=0, busy=0, flush_done=0, underrun=0, fill_cnt=0, phase=0.
- in_ready is combinational from state and phase only. It never depends on in_valid.
- An accept at edge k gives tdl_shift=1 and tdl_in=bit in cycle k+1.
- Accepts after the first occur every OSR clocks; with OSR=1, every cycle.
- out_valid rises the cycle after the (SPAN+1)-th tdl_shift pulse.
- In FLUSH, flush_done is high the cycle after the SPAN-th zero tdl_shift. At that point the last data bit is on tap SPAN. IDLE starts the following cycle.
- A new accept is possible in the first IDLE cycle.
- Reset low mid-burst: all registers return to reset values at that edge, with no flush and no flush_done.
- Slot with in_valid && in_last in FILL: last bit shifted, then FLUSH. fill_cnt keeps counting through the flush.

## Structure
- Shared package tdl_pkg:
  - State encoding constants.
  - A clog2-based width function for phase and fill counters.
  - SPAN default.
- One sub-module: tdl_slot_timer, the phase counter with slot strobe and a clear input.
- The remainder is the FSM plus the fill and flush counters in tdl_sequencer.

## Test plan
- Streaming: SPAN=16, OSR=4, 40 bits alternating 1/0, in_valid held high, in_last on bit 40.
  - in_ready every 4 clocks; tdl_shift pulses with the matching bits.
  - out_valid rises after the 17th pulse.
  - 16 zero shifts follow bit 40, then flush_done, then busy=0.
- Underrun: stream 20 bits, drop in_valid for 3 slots, resume.
  - Three zero shifts; underrun=1 and stays 1 through the end of the burst.
  - State stays RUN.
- Short burst: 5 bits, last on bit 5.
  - out_valid rises after shift 17 (the 12th flush zero).
  - flush_done after the 16th zero.
  - 21 tdl_shift pulses in total.
- OSR=1: 20 bits back to back.
  - Accept every cycle; out_valid rises 2 cycles after the 17th accept.
- Reset mid-burst: reset low for 1 cycle during RUN.
  - All outputs at reset values next cycle; no flush_done.
  - A new burst then starts cleanly from IDLE.
- Single-bit burst: in_last on the first bit.
  - 1 data shift plus 16 zero shifts, flush_done, immediate re-accept in IDLE.
